tft_draw_arb: RTL and testbench
===============================

Name: tft_draw_arb

Overview:
- Schedules and shares the single TFT SPI controller (tft_ctrl) among N_REQ rectangle/blit requesters.
- Issues the panel init sequence once after reset and again on a reinit request.
- Arbitrates draw requests round-robin and drives the controller's init/draw/busy handshake.
- Routes the live color and blit coordinates between the controller and the granted requester.

Parameters:
- N_REQ, 4, number of draw requesters (2..8).
- GNT_W, 2, width of the grant index; must be ≥ clog2(N_REQ).
- BUSY_TO, 15, cycles to wait for tft busy to rise after a command before flagging an error.

Ports:
- clk  in  1  system clock
- rstn  in  1  reset; asynchronous, active-low
- reinit  in  1  pulse; requests a panel re-initialisation
- req  in  N_REQ  per-requester level request; held until its ack
- req_color  in  16*N_REQ  per-requester color, rrrr rggg gggb bbbb; slice i = [16i+15:16i]
- req_xstart, req_xend, req_ystart, req_yend  in  16*N_REQ each  per-requester rectangle bounds
- ack  out  N_REQ  one-cycle pulse; the request was accepted by tft
- done  out  N_REQ  one-cycle pulse; the granted requester's draw has finished
- own  out  N_REQ  one-hot; requester currently being served
- cnext_o  out  N_REQ  tft cnext gated by own
- init_done  out  1  high once an init sequence has completed; cleared by reset or reinit
- err  out  1  sticky; tft busy failed to rise within BUSY_TO; cleared only by reset
- tft_init, tft_draw  out  1 each  to the controller's init/draw inputs
- tft_color, tft_xstart, tft_xend, tft_ystart, tft_yend  out  16 each  to the controller
- tft_busy, tft_cnext  in  1 each  from the controller

Behaviour:
- Reset values: state=FLUSH; all outputs 0; grant pointer=0; init pending=1.
- The controller has no reset. After rstn, stay in FLUSH until tft_busy=0 for 2 consecutive cycles, then go to INIT_GO.
- INIT_GO:
  - Assert tft_init.
  - When tft_busy=1, drop tft_init and go to WAIT_LO.
  - If tft_busy is not seen within BUSY_TO cycles: set err, drop tft_init, go to IDLE.
- WAIT_LO: when tft_busy=0, go to IDLE. Pulse done and clear own for a draw; set init_done for an init.
- IDLE:
  - If init is pending (set by reset or reinit), go to INIT_GO; clear init_done on entry.
  - Otherwise, if any req bit is set, choose the winner g by round-robin starting at (last grant + 1) mod N_REQ.
  - Register g; set own[g]; go to DRAW_GO.
  - Draws are not issued while init_done=0.
- DRAW_GO:
  - Assert tft_draw, with the rect outputs driven from slice g (registered at grant, stable until WAIT_LO exits).
  - When tft_busy=1: drop tft_draw, pulse ack[g], go to WAIT_LO.
  - Timeout is handled the same as in INIT_GO, plus: clear own and do not pulse ack.
- tft_color is a combinational mux of req_color by the registered g, live for the whole draw. cnext_o = own & {N_REQ{tft_cnext}}.
- Latency: draw rises the cycle after the grant. Busy is expected 2 cycles after the draw/init edge.
- reinit:
  - Latches a pending flag in any state.
  - It does not abort a draw in progress; it is served at the next IDLE, ahead of all requesters.
- Simultaneous events: a reinit and a req in the same cycle as IDLE evaluation → init wins. A deasserted req is never granted. A req that drops after grant is still completed.
- Async reset mid-draw: all outputs go to 0 immediately. FLUSH then absorbs the controller's remaining busy period.
- Round-robin wrap: a pointer at N_REQ-1 wraps to 0. With a single active requester, it is granted back-to-back.

Optional Feature:
- TFT_ARB_PRIO0_EN
- Defined: requester 0 has fixed highest priority (e.g. cursor overlay). Round-robin applies among 1..N_REQ-1 only when req[0]=0. Init still beats requester 0.
- Undefined: pure round-robin across all N_REQ requesters.

Decomposition:
- Package tft_pkg holds:
  - the state encodings (FLUSH, INIT_GO, DRAW_GO, WAIT_LO, IDLE);
  - the 16-bit coordinate/color width constant;
  - the RGB565 field positions.
- One sub-module, tft_rr_pick: combinational round-robin picker, inputs req and last grant, outputs winner index and valid. The PRIO0 override lives inside it.

Test Plan:
- Reset, tft_busy model high for 10 more cycles → tft_init stays 0 until busy has been low 2 cycles, then rises. init_done=1 after the modelled init busy falls.
- req=4'b1011 held, model busy 20 cycles per draw → grants in order 0,1,3,0. One ack and one done per draw. tft_xstart matches the granted slice.
- During a draw of requester 2, toggle req_color[2] on each tft_cnext → tft_color follows with zero lag. cnext_o=4'b0100 only.
- Model never raises busy → err=1 after 15 cycles in DRAW_GO. No ack. own cleared. Next requester served normally.
- reinit pulse mid-draw with req[1] pending → the draw completes. Next action is tft_init (init_done drops), then requester 1 is granted.
- With TFT_ARB_PRIO0_EN, req=4'b0111 with req[0] re-asserted after each done → requester 0 is granted every time. Without the macro: 0,1,2,0.

Source files
------------

// File: rtl/tft_pkg.sv
// Shared definitions for the TFT draw arbiter.
//   - tft_state_e : arbiter FSM state encodings
//   - TFT_W       : coordinate / color width
//   - RGB565 field positions and widths, plus an rgb565() packing helper
package tft_pkg;

    localparam int unsigned TFT_W = 16;

    // RGB565 layout: rrrr rggg gggb bbbb
    localparam int unsigned RGB_R_LSB = 11;
    localparam int unsigned RGB_R_W   = 5;
    localparam int unsigned RGB_G_LSB = 5;
    localparam int unsigned RGB_G_W   = 6;
    localparam int unsigned RGB_B_LSB = 0;
    localparam int unsigned RGB_B_W   = 5;

    typedef enum logic [2:0] {
        FLUSH   = 3'd0,
        INIT_GO = 3'd1,
        DRAW_GO = 3'd2,
        WAIT_LO = 3'd3,
        IDLE    = 3'd4
    } tft_state_e;

    typedef struct packed {
        logic [TFT_W-1:0] xstart;
        logic [TFT_W-1:0] xend;
        logic [TFT_W-1:0] ystart;
        logic [TFT_W-1:0] yend;
    } tft_rect_t;

    // Pack separate channels into one RGB565 word.
    function automatic logic [TFT_W-1:0] rgb565(input logic [RGB_R_W-1:0] r,
                                                input logic [RGB_G_W-1:0] g,
                                                input logic [RGB_B_W-1:0] b);
        return (TFT_W'(r) << RGB_R_LSB) | (TFT_W'(g) << RGB_G_LSB) | (TFT_W'(b) << RGB_B_LSB);
    endfunction

endpackage

// File: rtl/tft_rr_pick.sv
// Combinational round-robin picker for the TFT draw arbiter.
//   req   : per-requester request levels
//   ptr   : search start index (last grant + 1, wrapped)
//   win   : winning requester index
//   valid : at least one eligible request
// Build option TFT_ARB_PRIO0_EN: requester 0 always wins when it requests;
// otherwise the search is pure round-robin over all requesters.
module tft_rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned GNT_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [GNT_W-1:0] ptr,
    output logic [GNT_W-1:0] win,
    output logic             valid
);

    // First set request found walking upward from ptr, wrapping at N_REQ.
    always_comb begin
        int unsigned      idx;
        logic [N_REQ-1:0] sh;
        win   = '0;
        valid = 1'b0;
        idx   = 0;
        sh    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (32'(ptr) + k) % N_REQ;
            sh  = req >> idx;
            if (!valid && sh[0]) begin
                valid = 1'b1;
                win   = GNT_W'(idx);
            end
        end
`ifdef TFT_ARB_PRIO0_EN
        // Requester 0 (e.g. cursor overlay) pre-empts the rotation.
        if (req[0]) begin
            valid = 1'b1;
            win   = '0;
        end
`endif
    end

endmodule

// File: rtl/tft_draw_arb.sv
// Shares one TFT SPI controller among N_REQ rectangle/blit requesters.
// Runs the panel init sequence after reset and on reinit, then grants
// draw requests round-robin and drives the controller's init/draw/busy
// handshake.
// Ports:
//   clk, rstn                   : clock, async active-low reset
//   reinit                      : pulse, request panel re-initialisation
//   req / req_color / req_*     : per-requester request and rectangle (16-bit slices)
//   ack, done                   : per-requester one-cycle pulses
//   own                         : one-hot requester being served
//   cnext_o                     : controller cnext routed to the owner
//   init_done, err              : init complete / sticky busy timeout
//   tft_init, tft_draw, tft_*   : controller command and rectangle outputs
//   tft_busy, tft_cnext         : controller status inputs
// tft_color and cnext_o are combinational so color streaming has no lag.
// Build option TFT_ARB_PRIO0_EN (in tft_rr_pick): requester 0 has fixed
// highest priority.
module tft_draw_arb
    import tft_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned GNT_W   = 2,
    parameter int unsigned BUSY_TO = 15
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   reinit,
    input  logic [N_REQ-1:0]       req,
    input  logic [TFT_W*N_REQ-1:0] req_color,
    input  logic [TFT_W*N_REQ-1:0] req_xstart,
    input  logic [TFT_W*N_REQ-1:0] req_xend,
    input  logic [TFT_W*N_REQ-1:0] req_ystart,
    input  logic [TFT_W*N_REQ-1:0] req_yend,
    output logic [N_REQ-1:0]       ack,
    output logic [N_REQ-1:0]       done,
    output logic [N_REQ-1:0]       own,
    output logic [N_REQ-1:0]       cnext_o,
    output logic                   init_done,
    output logic                   err,
    output logic                   tft_init,
    output logic                   tft_draw,
    output logic [TFT_W-1:0]       tft_color,
    output logic [TFT_W-1:0]       tft_xstart,
    output logic [TFT_W-1:0]       tft_xend,
    output logic [TFT_W-1:0]       tft_ystart,
    output logic [TFT_W-1:0]       tft_yend,
    input  logic                   tft_busy,
    input  logic                   tft_cnext
);

    localparam int unsigned      TO_W    = $clog2(BUSY_TO + 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(BUSY_TO - 1);

    tft_state_e       state_q, state_d;
    logic             flush_cnt_q, flush_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             op_init_q, op_init_d;
    logic             init_pend_q, init_pend_d;
    logic [GNT_W-1:0] g_q, g_d;
    logic [GNT_W-1:0] ptr_q, ptr_d;
    logic [N_REQ-1:0] own_q, own_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic             init_done_q, init_done_d;
    logic             err_q, err_d;
    logic             tft_init_q, tft_init_d;
    logic             tft_draw_q, tft_draw_d;
    tft_rect_t        rect_q, rect_d;

    logic [GNT_W-1:0] pick_win;
    logic             pick_valid;
    logic             pend_now;

    tft_rr_pick #(
        .N_REQ (N_REQ),
        .GNT_W (GNT_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .win   (pick_win),
        .valid (pick_valid)
    );

    // A reinit arriving in the IDLE evaluation cycle still beats requesters.
    assign pend_now = init_pend_q | reinit;

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= FLUSH;
            flush_cnt_q <= 1'b0;
            to_cnt_q    <= '0;
            op_init_q   <= 1'b0;
            init_pend_q <= 1'b1;
            g_q         <= '0;
            ptr_q       <= '0;
            own_q       <= '0;
            ack_q       <= '0;
            done_q      <= '0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
            tft_init_q  <= 1'b0;
            tft_draw_q  <= 1'b0;
            rect_q      <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            to_cnt_q    <= to_cnt_d;
            op_init_q   <= op_init_d;
            init_pend_q <= init_pend_d;
            g_q         <= g_d;
            ptr_q       <= ptr_d;
            own_q       <= own_d;
            ack_q       <= ack_d;
            done_q      <= done_d;
            init_done_q <= init_done_d;
            err_q       <= err_d;
            tft_init_q  <= tft_init_d;
            tft_draw_q  <= tft_draw_d;
            rect_q      <= rect_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        to_cnt_d    = to_cnt_q;
        op_init_d   = op_init_q;
        init_pend_d = init_pend_q | reinit;
        g_d         = g_q;
        ptr_d       = ptr_q;
        own_d       = own_q;
        ack_d       = '0;
        done_d      = '0;
        init_done_d = init_done_q;
        err_d       = err_q;
        tft_init_d  = tft_init_q;
        tft_draw_d  = tft_draw_q;
        rect_d      = rect_q;

        unique case (state_q)
            // Controller is not reset with us: wait out any busy period it is in.
            FLUSH: begin
                if (tft_busy) begin
                    flush_cnt_d = 1'b0;
                end else if (flush_cnt_q) begin
                    flush_cnt_d = 1'b0;
                    state_d     = INIT_GO;
                    tft_init_d  = 1'b1;
                    op_init_d   = 1'b1;
                    to_cnt_d    = '0;
                    init_pend_d = 1'b0;
                    init_done_d = 1'b0;
                end else begin
                    flush_cnt_d = 1'b1;
                end
            end

            INIT_GO: begin
                if (tft_busy) begin
                    tft_init_d = 1'b0;
                    state_d    = WAIT_LO;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d      = 1'b1;
                    tft_init_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end

            DRAW_GO: begin
                if (tft_busy) begin
                    tft_draw_d = 1'b0;
                    ack_d      = own_q;
                    state_d    = WAIT_LO;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d      = 1'b1;
                    tft_draw_d = 1'b0;
                    own_d      = '0;
                    state_d    = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end

            WAIT_LO: begin
                if (!tft_busy) begin
                    state_d = IDLE;
                    if (op_init_q) begin
                        init_done_d = 1'b1;
                    end else begin
                        done_d = own_q;
                        own_d  = '0;
                    end
                end
            end

            IDLE: begin
                if (pend_now) begin
                    state_d     = INIT_GO;
                    tft_init_d  = 1'b1;
                    op_init_d   = 1'b1;
                    to_cnt_d    = '0;
                    init_pend_d = 1'b0;
                    init_done_d = 1'b0;
                end else if (init_done_q && pick_valid) begin
                    state_d       = DRAW_GO;
                    tft_draw_d    = 1'b1;
                    op_init_d     = 1'b0;
                    to_cnt_d      = '0;
                    g_d           = pick_win;
                    own_d         = N_REQ'(1) << pick_win;
                    ptr_d         = (32'(pick_win) == N_REQ - 1) ? '0 : pick_win + GNT_W'(1);
                    rect_d.xstart = TFT_W'(req_xstart >> (TFT_W * 32'(pick_win)));
                    rect_d.xend   = TFT_W'(req_xend   >> (TFT_W * 32'(pick_win)));
                    rect_d.ystart = TFT_W'(req_ystart >> (TFT_W * 32'(pick_win)));
                    rect_d.yend   = TFT_W'(req_yend   >> (TFT_W * 32'(pick_win)));
                end
            end

            default: begin
                state_d = FLUSH;
            end
        endcase
    end

    assign ack        = ack_q;
    assign done       = done_q;
    assign own        = own_q;
    assign init_done  = init_done_q;
    assign err        = err_q;
    assign tft_init   = tft_init_q;
    assign tft_draw   = tft_draw_q;
    assign tft_xstart = rect_q.xstart;
    assign tft_xend   = rect_q.xend;
    assign tft_ystart = rect_q.ystart;
    assign tft_yend   = rect_q.yend;

    // Live color from the owner; zero when nobody is being served.
    assign tft_color = (|own_q) ? TFT_W'(req_color >> (TFT_W * 32'(g_q))) : '0;
    assign cnext_o   = own_q & {N_REQ{tft_cnext}};

endmodule

// File: tb/tb_tft_draw_arb.sv
// Directed bench for tft_draw_arb with a simple tft_ctrl busy model.
module tb_tft_draw_arb;
    import tft_pkg::*;

    localparam int unsigned N = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic             reinit;
    logic [N-1:0]     req;
    logic [16*N-1:0]  req_color, req_xstart, req_xend, req_ystart, req_yend;
    logic [N-1:0]     ack, done, own, cnext_o;
    logic             init_done, err, tft_init, tft_draw;
    logic [15:0]      tft_color, tft_xstart, tft_xend, tft_ystart, tft_yend;
    logic             tft_busy, tft_cnext;

    int n_cmp = 0;
    int n_bad = 0;

    // Controller model: busy rises 2 cycles after an init/draw rising edge.
    int   bcnt      = 12;
    int   model_len = 20;
    bit   model_off = 1'b0;
    logic cmd_q     = 1'b0;
    logic pend      = 1'b0;

    assign tft_busy = (bcnt != 0);

    always @(posedge clk) begin
        cmd_q <= tft_init | tft_draw;
        pend  <= (tft_init | tft_draw) && !cmd_q && !model_off;
        if (pend) bcnt <= model_len;
        else if (bcnt != 0) bcnt <= bcnt - 1;
    end

    always #5 clk = ~clk;

    tft_draw_arb dut (
        .clk        (clk),
        .rstn       (rstn),
        .reinit     (reinit),
        .req        (req),
        .req_color  (req_color),
        .req_xstart (req_xstart),
        .req_xend   (req_xend),
        .req_ystart (req_ystart),
        .req_yend   (req_yend),
        .ack        (ack),
        .done       (done),
        .own        (own),
        .cnext_o    (cnext_o),
        .init_done  (init_done),
        .err        (err),
        .tft_init   (tft_init),
        .tft_draw   (tft_draw),
        .tft_color  (tft_color),
        .tft_xstart (tft_xstart),
        .tft_xend   (tft_xend),
        .tft_ystart (tft_ystart),
        .tft_yend   (tft_yend),
        .tft_busy   (tft_busy),
        .tft_cnext  (tft_cnext)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // which: 0 ack, 1 done, 2 init_done, 3 own==val, 4 err
    task automatic wait_ev(input string tag, input int which, input logic [3:0] val);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            case (which)
                0: hit = (ack != '0);
                1: hit = (done != '0);
                2: hit = init_done;
                3: hit = (own == val);
                default: hit = err;
            endcase
            if (hit) break;
        end
        chk({tag, "_seen"}, 32'(hit), 32'd1);
    endtask

    logic [3:0] exp_rr  [4];
    logic [3:0] exp_pr  [4];

    initial begin
`ifdef TFT_ARB_PRIO0_EN
        exp_rr[0] = 4'b0001; exp_rr[1] = 4'b0001; exp_rr[2] = 4'b0001; exp_rr[3] = 4'b0001;
        exp_pr[0] = 4'b0001; exp_pr[1] = 4'b0001; exp_pr[2] = 4'b0001; exp_pr[3] = 4'b0001;
`else
        exp_rr[0] = 4'b0001; exp_rr[1] = 4'b0010; exp_rr[2] = 4'b1000; exp_rr[3] = 4'b0001;
        exp_pr[0] = 4'b0001; exp_pr[1] = 4'b0010; exp_pr[2] = 4'b0100; exp_pr[3] = 4'b0001;
`endif
        rstn      = 1'b0;
        reinit    = 1'b0;
        req       = '0;
        tft_cnext = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_color [16*i +: 16] = 16'h1111 * 16'(i + 1);
            req_xstart[16*i +: 16] = 16'(100 + i);
            req_xend  [16*i +: 16] = 16'(200 + i);
            req_ystart[16*i +: 16] = 16'(300 + i);
            req_yend  [16*i +: 16] = 16'(400 + i);
        end

        // Reset state.
        tick();
        chk("rst_init",   32'(tft_init),  32'd0);
        chk("rst_draw",   32'(tft_draw),  32'd0);
        chk("rst_own",    32'(own),       32'd0);
        chk("rst_ack",    32'(ack),       32'd0);
        chk("rst_done",   32'(done),      32'd0);
        chk("rst_idone",  32'(init_done), 32'd0);
        chk("rst_err",    32'(err),       32'd0);
        chk("rst_color",  32'(tft_color), 32'd0);
        chk("rst_cnext",  32'(cnext_o),   32'd0);
        chk("rst_xstart", 32'(tft_xstart), 32'd0);
        tick();
        rstn      = 1'b1;
        tft_cnext = 1'b0;

        // Flush: no init while controller is still busy, then two low cycles.
        for (int i = 0; i < 30 && tft_busy; i++) begin
            chk("flush_init_low", 32'(tft_init), 32'd0);
            tick();
        end
        tick();
        chk("flush_one_low", 32'(tft_init), 32'd0);
        tick();
        chk("flush_init_go", 32'(tft_init), 32'd1);
        wait_ev("init_done", 2, 4'b0);
        chk("init_idone", 32'(init_done), 32'd1);
        chk("init_err",   32'(err),       32'd0);

        // Round-robin over 1011.
        req = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            wait_ev("rr_ack", 0, 4'b0);
            chk("rr_ack",    32'(ack),  32'(exp_rr[k]));
            chk("rr_own",    32'(own),  32'(exp_rr[k]));
            chk("rr_drawlo", 32'(tft_draw), 32'd0);
            chk("rr_xstart", 32'(tft_xstart), 32'($clog2(exp_rr[k])) + 32'd100);
            chk("rr_yend",   32'(tft_yend),   32'($clog2(exp_rr[k])) + 32'd400);
            if (k == 3) req = '0;
            tick();
            chk("rr_ack_pulse", 32'(ack), 32'd0);
            wait_ev("rr_done", 1, 4'b0);
            chk("rr_done",  32'(done), 32'(exp_rr[k]));
            chk("rr_ownlo", 32'(own),  32'd0);
            tick();
            chk("rr_done_pulse", 32'(done), 32'd0);
            if (k < 3) begin
                chk("rr_draw_lat", 32'(tft_draw), 32'd1);
                chk("rr_own_next", 32'(own),      32'(exp_rr[k+1]));
            end
        end

        // Live color / cnext routing for requester 2.
        req = 4'b0100;
        wait_ev("col_own", 3, 4'b0100);
        tft_cnext = 1'b1;
        req_color[32 +: 16] = rgb565(5'h1F, 6'h00, 5'h00);
        #1;
        chk("col_red",    32'(tft_color), 32'h0000_F800);
        chk("col_cnext1", 32'(cnext_o),   32'h4);
        tft_cnext = 1'b0;
        req_color[32 +: 16] = rgb565(5'h00, 6'h3F, 5'h00);
        #1;
        chk("col_green",  32'(tft_color), 32'h0000_07E0);
        chk("col_cnext0", 32'(cnext_o),   32'h0);
        tft_cnext = 1'b1;
        req_color[32 +: 16] = rgb565(5'h00, 6'h00, 5'h1F);
        #1;
        chk("col_blue",   32'(tft_color), 32'h0000_001F);
        tft_cnext = 1'b0;
        wait_ev("col_ack", 0, 4'b0);
        chk("col_ack", 32'(ack), 32'h4);
        req = '0;
        wait_ev("col_done", 1, 4'b0);
        chk("col_done", 32'(done), 32'h4);

        // Busy never rises: timeout after BUSY_TO cycles in DRAW_GO.
        model_off = 1'b1;
        req = 4'b0010;
        wait_ev("to_own", 3, 4'b0010);
        for (int i = 0; i < 14; i++) begin
            tick();
            chk("to_noack", 32'(ack), 32'd0);
            chk("to_noerr", 32'(err), 32'd0);
        end
        tick();
        chk("to_err",   32'(err),      32'd1);
        chk("to_own",   32'(own),      32'd0);
        chk("to_draw",  32'(tft_draw), 32'd0);
        req = 4'b1000;
        model_off = 1'b0;
        wait_ev("to_next_ack", 0, 4'b0);
        chk("to_next_ack", 32'(ack), 32'h8);
        req = '0;
        wait_ev("to_next_done", 1, 4'b0);
        chk("to_next_done", 32'(done), 32'h8);

        // Reinit mid-draw with requester 1 pending.
        req = 4'b0001;
        wait_ev("ri_ack0", 0, 4'b0);
        chk("ri_ack0", 32'(ack), 32'h1);
        req    = 4'b0010;
        reinit = 1'b1;
        tick();
        reinit = 1'b0;
        wait_ev("ri_done0", 1, 4'b0);
        chk("ri_done0", 32'(done),      32'h1);
        chk("ri_idone_hold", 32'(init_done), 32'd1);
        tick();
        chk("ri_init",  32'(tft_init),  32'd1);
        chk("ri_idone", 32'(init_done), 32'd0);
        chk("ri_own",   32'(own),       32'd0);
        wait_ev("ri_ack1", 0, 4'b0);
        chk("ri_ack1",   32'(ack),       32'h2);
        chk("ri_idone2", 32'(init_done), 32'd1);
        req = '0;
        wait_ev("ri_done1", 1, 4'b0);

        // Align pointer to 0 via requester 3, then the priority scenario.
        req = 4'b1000;
        wait_ev("pr_align", 0, 4'b0);
        req = '0;
        wait_ev("pr_align_done", 1, 4'b0);
        req = 4'b0111;
        for (int k = 0; k < 4; k++) begin
            wait_ev("pr_ack", 0, 4'b0);
            chk("pr_ack", 32'(ack), 32'(exp_pr[k]));
            if (k == 3) req = '0;
            else if (ack[0]) req[0] = 1'b0;
            wait_ev("pr_done", 1, 4'b0);
            chk("pr_done", 32'(done), 32'(exp_pr[k]));
            if (k < 3) req[0] = 1'b1;
        end

        // Async reset mid-draw.
        req = 4'b0001;
        wait_ev("ar_ack", 0, 4'b0);
        req = '0;
        tick();
        rstn = 1'b0;
        #1;
        chk("ar_own",   32'(own),       32'd0);
        chk("ar_draw",  32'(tft_draw),  32'd0);
        chk("ar_err",   32'(err),       32'd0);
        chk("ar_idone", 32'(init_done), 32'd0);
        chk("ar_busy_still", 32'(tft_busy), 32'd1);
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 40 && tft_busy; i++) begin
            chk("ar_flush_init_low", 32'(tft_init), 32'd0);
            tick();
        end
        wait_ev("ar_init_done", 2, 4'b0);
        chk("ar_own_idle", 32'(own), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
